zero_sleep_monitor: RTL
=======================

Name: zero_sleep_monitor

Overview:
- Sits directly downstream of the serial-to-parallel input stage, in the data-input phase of the stereo audio processor.
- Watches each reassembled stereo sample pair as it is written to data memory and counts consecutive all-zero pairs.
- After ZERO_LIMIT consecutive zero pairs it enters sleep and suppresses further zero writes.
- On the first non-zero pair it issues a one-cycle wakeupSignal, which the input stage and controller use to realign indices, and it resumes normal operation.

Parameters:
- DATA_WIDTH, 16, width of each channel sample.
- ZERO_LIMIT, 800, number of consecutive zero pairs that triggers sleep.
- CNT_WIDTH, 10, width of the zero counter; 2^CNT_WIDTH must be greater than ZERO_LIMIT.

Ports:
- dClk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high while the FSM is in the data-read state.
- dataWriteL  input  1  left write strobe from the S2P stage; a level held until the next frame.
- dataWriteR  input  1  right write strobe from the S2P stage.
- toMemL  input  DATA_WIDTH  left sample, valid while dataWriteL is high.
- toMemR  input  DATA_WIDTH  right sample, valid while dataWriteR is high.
- storeEn  output  1  one-cycle qualifier: the pair shall be committed to data memory.
- sleepFlag  output  1  high while in SLEEP.
- wakeupSignal  output  1  one-cycle pulse on SLEEP to AWAKE.
- zeroCount  output  CNT_WIDTH  current count of consecutive zero pairs.
- monState  output  2  encoded state: 0 IDLE, 1 AWAKE, 2 SLEEP.

Behaviour:
- Clock and reset: one clock, dClk. reset is synchronous and active-high.
- Reset values: storeEn=0, sleepFlag=0, wakeupSignal=0, zeroCount=0, monState=IDLE, pair-strobe history register=0.
- Reset mid-operation, including in SLEEP: all of the above are cleared on the next edge, with no wakeupSignal pulse.
- Pair strobe: wr = dataWriteL & dataWriteR. A sample event is wr=1 with registered wr_d=0 (rising edge).
  - A long-held wr produces exactly one event.
  - Only one channel high is never an event.
- Zero test: isZero = (toMemL==0) && (toMemR==0), sampled in the event cycle.
- Latency: every output reacts at the dClk edge closing the event cycle (1-cycle registered latency).
- storeEn and wakeupSignal are high for exactly one cycle.
- IDLE:
  - Events are ignored and storeEn stays 0.
  - enable=1 moves to AWAKE with zeroCount=0.
- AWAKE:
  - Each event asserts storeEn.
  - isZero: zeroCount increments, saturating at ZERO_LIMIT.
  - Non-zero: zeroCount resets to 0.
  - When the increment reaches ZERO_LIMIT, go to SLEEP and set sleepFlag on the same edge. The ZERO_LIMIT-th zero pair itself is stored.
- SLEEP:
  - Zero events: storeEn=0, zeroCount holds at ZERO_LIMIT.
  - Non-zero event: storeEn=1, wakeupSignal=1, sleepFlag=0, zeroCount=0, go to AWAKE.
- enable deasserts in any state: go to IDLE next edge with zeroCount=0 and sleepFlag=0. No wakeupSignal pulse. A simultaneous event is dropped.
- Event on the same edge enable rises (from IDLE): dropped; only the IDLE to AWAKE transition occurs.
- The history register wr_d updates every cycle in every state. An event pending when entering AWAKE is not replayed.
- Illegal monState encoding 3: recover to IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/AWAKE/SLEEP;
  - DATA_WIDTH;
  - ZERO_LIMIT;
  - the FSMState code for the data phase (4'b0110), so the controller drives enable consistently.
- One natural sub-module: pair_edge_detect (wr AND plus registered rising-edge detect), reused by other memory-write consumers.
- Counter and FSM stay in the top.

Test Plan:
- Reset then enable=1: monState IDLE→AWAKE after one edge. 5 events with L=0x0001, R=0x0000 → 5 storeEn pulses, zeroCount stays 0, sleepFlag=0.
- 800 zero pair events:
  - event 799 leaves zeroCount=799 and AWAKE;
  - event 800 gives storeEn=1, zeroCount=800, sleepFlag=1, monState=SLEEP.
- In SLEEP, 10 zero events then L=0x1234, R=0x0000:
  - no storeEn during the zeros;
  - the non-zero event yields storeEn=1, wakeupSignal=1 for one cycle, zeroCount=0, monState=AWAKE.
- wr held high for 20 cycles → exactly one storeEn. dataWriteL=1 with dataWriteR=0 → no storeEn.
- 799 zeros, one non-zero pair, then 799 zeros → no sleep, zeroCount=799.
- reset asserted in SLEEP → all outputs 0, monState=IDLE, no wakeupSignal pulse. enable dropped in SLEEP → IDLE, sleepFlag=0 next edge.

Source files
------------

// File: rtl/zero_sleep_monitor_pkg.sv
// Shared constants for the zero-sleep monitor and the controller that drives its enable.
package zero_sleep_monitor_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ZERO_LIMIT = 800;
    localparam int unsigned CNT_WIDTH  = 10;

    localparam logic [1:0] MonIdle  = 2'd0;
    localparam logic [1:0] MonAwake = 2'd1;
    localparam logic [1:0] MonSleep = 2'd2;

    // Controller FSMState code for the data-read phase; enable is high only in this state.
    localparam logic [3:0] FsmDataRead = 4'b0110;

endpackage

// File: rtl/zero_sleep_monitor_pair_edge_detect.sv
// Combines the left/right write strobes into a pair strobe and flags its rising edge.
module zero_sleep_monitor_pair_edge_detect (
    input  logic dClk,
    input  logic reset,
    input  logic dataWriteL,
    input  logic dataWriteR,
    output logic pairEvent
);

    logic wrNow;
    logic wrQ;

    assign wrNow = dataWriteL & dataWriteR;

    always_ff @(posedge dClk) begin
        if (reset) begin
            wrQ <= 1'b0;
        end else begin
            wrQ <= wrNow;
        end
    end

    assign pairEvent = wrNow & ~wrQ;

endmodule

// File: rtl/zero_sleep_monitor.sv
// Counts consecutive all-zero stereo pairs, sleeps after ZERO_LIMIT of them and
// pulses wakeupSignal on the first non-zero pair seen while asleep.
module zero_sleep_monitor #(
    parameter int unsigned DATA_WIDTH = zero_sleep_monitor_pkg::DATA_WIDTH,
    parameter int unsigned ZERO_LIMIT = zero_sleep_monitor_pkg::ZERO_LIMIT,
    parameter int unsigned CNT_WIDTH  = zero_sleep_monitor_pkg::CNT_WIDTH
) (
    input  logic                  dClk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dataWriteL,
    input  logic                  dataWriteR,
    input  logic [DATA_WIDTH-1:0] toMemL,
    input  logic [DATA_WIDTH-1:0] toMemR,
    output logic                  storeEn,
    output logic                  sleepFlag,
    output logic                  wakeupSignal,
    output logic [CNT_WIDTH-1:0]  zeroCount,
    output logic [1:0]            monState
);
    import zero_sleep_monitor_pkg::*;

    localparam logic [CNT_WIDTH-1:0] LimitCnt = CNT_WIDTH'(ZERO_LIMIT);

    logic                 pairEvent;
    logic                 isZero;
    logic [1:0]           stateQ, stateD;
    logic [CNT_WIDTH-1:0] countQ, countD;
    logic                 storeQ, storeD;
    logic                 wakeQ, wakeD;

    zero_sleep_monitor_pair_edge_detect u_edge (
        .dClk       (dClk),
        .reset      (reset),
        .dataWriteL (dataWriteL),
        .dataWriteR (dataWriteR),
        .pairEvent  (pairEvent)
    );

    assign isZero = (toMemL == '0) && (toMemR == '0);

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        storeD = 1'b0;
        wakeD  = 1'b0;
        // Losing enable wins over everything, including an event on the same edge.
        if (!enable) begin
            stateD = MonIdle;
            countD = '0;
        end else begin
            case (stateQ)
                MonIdle: begin
                    stateD = MonAwake;
                    countD = '0;
                end
                MonAwake: begin
                    if (pairEvent) begin
                        storeD = 1'b1;
                        if (!isZero) begin
                            countD = '0;
                        end else if (countQ >= LimitCnt - 1'b1) begin
                            countD = LimitCnt;
                            stateD = MonSleep;
                        end else begin
                            countD = countQ + 1'b1;
                        end
                    end
                end
                MonSleep: begin
                    if (pairEvent && !isZero) begin
                        storeD = 1'b1;
                        wakeD  = 1'b1;
                        countD = '0;
                        stateD = MonAwake;
                    end
                end
                default: begin
                    stateD = MonIdle;
                    countD = '0;
                end
            endcase
        end
    end

    always_ff @(posedge dClk) begin
        if (reset) begin
            stateQ <= MonIdle;
            countQ <= '0;
            storeQ <= 1'b0;
            wakeQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            storeQ <= storeD;
            wakeQ  <= wakeD;
        end
    end

    assign storeEn      = storeQ;
    assign wakeupSignal = wakeQ;
    assign sleepFlag    = (stateQ == MonSleep);
    assign zeroCount    = countQ;
    assign monState     = stateQ;

endmodule
